// File: rtl/pcie_bf_para_buf_pkg.sv
// Shared constants, helpers and write-FSM state encodings for the
// beamforming-parameter buffer.
package pcie_bf_para_buf_pkg;

    // Width of the per-page info field taken from beat 0 of each packet.
    localparam int INFO_W = 24;

    // Write FSM states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_DROP   = 2'd3;

    // Address width for n entries; never less than one bit so that
    // single-entry dimensions still produce a legal vector.
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beats in one complete parameter packet.
    function automatic int pkt_beats(input int num_ch, input int rec_beats);
        return num_ch * rec_beats;
    endfunction

endpackage

// File: rtl/pcie_bf_para_buf_sdp_ram_bytewr.sv
// Simple dual-port RAM: wide byte-enabled write port, narrow read port
// with an RD_LAT-deep output pipeline. The narrow word is picked out of
// the addressed beat inside this wrapper.
module sdp_ram_bytewr
    import pcie_bf_para_buf_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int RD_W   = 32,
    parameter int DEPTH  = 20,
    parameter int RD_LAT = 3
) (
    input  logic                                w_clk,
    input  logic                                w_rst,
    input  logic [DATA_W/8-1:0]                 wr_be,
    input  logic [clog2w(DEPTH)-1:0]            wr_addr,
    input  logic [DATA_W-1:0]                   wr_data,
    input  logic                                rd_en,
    input  logic [clog2w(DEPTH)-1:0]            rd_addr,
    input  logic [clog2w(DATA_W/RD_W)-1:0]      rd_sel,
    output logic [RD_W-1:0]                     rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [RD_W-1:0]   rd_pipe_p [RD_LAT];

    // Byte-granular write; only enabled bytes of the beat are touched.
    always_ff @(posedge w_clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_be[b]) begin
                mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Stage p0 captures the selected word on a read; later stages just shift,
    // so back-to-back reads stream out back-to-back.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe_p[i] <= '0;
            end
        end else begin
            if (rd_en) begin
                rd_pipe_p[0] <= mem[rd_addr][32'(rd_sel)*RD_W +: RD_W];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe_p[i] <= rd_pipe_p[i-1];
            end
        end
    end

    assign rd_data = rd_pipe_p[RD_LAT-1];

endmodule

// File: rtl/pcie_bf_para_buf.sv
// Beamforming-parameter buffer: unpacks PCIe packets into a circular set of
// pages, checks packet framing, drops packets when no page is free, and
// serves the oldest filled page to the coefficient loader as narrow words.
// NPAGE must be a power of two so the page pointers wrap naturally.
module pcie_bf_para_buf
    import pcie_bf_para_buf_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int RD_W      = 32,
    parameter int NUM_CH    = 2,
    parameter int REC_BEATS = 5,
    parameter int NPAGE     = 2,
    parameter int RD_LAT    = 3
) (
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic [DATA_W-1:0]         pcie_data,
    input  logic [DATA_W/8-1:0]       pcie_keep,
    input  logic                      pcie_valid,
    input  logic                      pcie_last,
    output logic                      rd_page_vld,
    output logic [INFO_W-1:0]         rd_info,
    input  logic                      rd_en,
    input  logic [clog2w(NUM_CH)+clog2w(REC_BEATS*DATA_W/RD_W)-1:0] rd_addr,
    output logic [RD_W-1:0]           rd_data,
    output logic                      rd_vld,
    input  logic                      rd_release,
    output logic [clog2w(NPAGE+1)-1:0] free_pages,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               err_cnt
);

    localparam int PKT_BEATS = pkt_beats(NUM_CH, REC_BEATS);
    localparam int WPB       = DATA_W / RD_W;
    localparam int CH_W      = clog2w(NUM_CH);
    localparam int WD_W      = clog2w(REC_BEATS * WPB);
    localparam int PG_W      = clog2w(NPAGE);
    localparam int BC_W      = clog2w(PKT_BEATS + 1);
    localparam int DEPTH     = NPAGE * PKT_BEATS;
    localparam int BA_W      = clog2w(DEPTH);
    localparam int SEL_W     = clog2w(WPB);
    localparam int FP_W      = clog2w(NPAGE + 1);

    logic [1:0]          state;
    logic [BC_W-1:0]     beat_cnt;
    logic [PG_W-1:0]     wr_ptr, rd_ptr, new_page;
    logic [FP_W-1:0]     free_q, fill_q;
    logic [15:0]         drop_q, err_q;
    logic [INFO_W-1:0]   info_mem [NPAGE];
    logic [RD_LAT-1:0]   vld_p;

    logic                first_slot, commit, has_room, release_ok, wr_go;
    logic [BC_W-1:0]     wr_idx;
    logic [BA_W-1:0]     wr_beat, rd_beat;
    logic [SEL_W-1:0]    rd_sel;
    logic [DATA_W/8-1:0] wr_be;
    logic [CH_W-1:0]     rd_ch;
    logic [WD_W-1:0]     rd_word;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Write-side decode. A beat seen during COMMIT opens the next packet, so
    // it lands on the page after the one being committed and must see the
    // free count as if that commit had already happened.
    always_comb begin
        first_slot = (state == ST_IDLE) || (state == ST_COMMIT);
        commit     = (state == ST_COMMIT);
        has_room   = commit ? (free_q > FP_W'(1)) : (free_q != '0);
        new_page   = commit ? wr_ptr + PG_W'(1) : wr_ptr;
        release_ok = rd_release && (fill_q != '0);
        wr_go      = pcie_valid &&
                     ((first_slot && has_room) ||
                      ((state == ST_WRITE) && (beat_cnt < BC_W'(PKT_BEATS))));
        wr_idx     = first_slot ? '0 : beat_cnt;
        wr_beat    = BA_W'(new_page) * BA_W'(PKT_BEATS) + BA_W'(wr_idx);
        wr_be      = wr_go ? pcie_keep : '0;
    end

    // Read-side decode: {channel, word} within the head page.
    always_comb begin
        rd_ch   = rd_addr[CH_W+WD_W-1 -: CH_W];
        rd_word = rd_addr[WD_W-1:0];
        rd_beat = BA_W'(rd_ptr) * BA_W'(PKT_BEATS) + BA_W'(rd_ch) * BA_W'(REC_BEATS)
                  + BA_W'(32'(rd_word) / WPB);
        rd_sel  = SEL_W'(32'(rd_word) % WPB);
    end

    // Packet framing FSM with beat counting and error/drop accounting.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            drop_q   <= '0;
            err_q    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (pcie_valid) begin
                        if (!has_room) begin
                            drop_q <= sat_inc(drop_q);
                            state  <= pcie_last ? ST_IDLE : ST_DROP;
                        end else if (pcie_last && (PKT_BEATS > 1)) begin
                            err_q <= sat_inc(err_q);
                        end else if (pcie_last) begin
                            state <= ST_COMMIT;
                        end else begin
                            state    <= ST_WRITE;
                            beat_cnt <= BC_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (pcie_valid) begin
                        if (beat_cnt == BC_W'(PKT_BEATS)) begin
                            // Overlong: discard page and swallow the rest.
                            err_q <= sat_inc(err_q);
                            state <= pcie_last ? ST_IDLE : ST_DROP;
                        end else if (pcie_last) begin
                            if (beat_cnt == BC_W'(PKT_BEATS-1)) begin
                                state <= ST_COMMIT;
                            end else begin
                                err_q <= sat_inc(err_q);
                                state <= ST_IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BC_W'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (pcie_valid && pcie_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Info field of each page is captured from beat 0 as it is written.
    always_ff @(posedge w_clk) begin
        if (wr_go && first_slot) begin
            info_mem[new_page] <= pcie_data[INFO_W-1:0];
        end
    end

    // Circular page pointers and free/filled occupancy.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            free_q <= FP_W'(NPAGE);
            fill_q <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + PG_W'(1);
            end
            if (release_ok) begin
                rd_ptr <= rd_ptr + PG_W'(1);
            end
            case ({commit, release_ok})
                2'b10: begin
                    free_q <= free_q - FP_W'(1);
                    fill_q <= fill_q + FP_W'(1);
                end
                2'b01: begin
                    free_q <= free_q + FP_W'(1);
                    fill_q <= fill_q - FP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Read valid tracks rd_en through the same depth as the RAM data pipe.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    sdp_ram_bytewr #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .wr_be   (wr_be),
        .wr_addr (wr_beat),
        .wr_data (pcie_data),
        .rd_en   (rd_en),
        .rd_addr (rd_beat),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    assign rd_vld      = vld_p[RD_LAT-1];
    assign rd_page_vld = (fill_q != '0);
    assign rd_info     = rd_page_vld ? info_mem[rd_ptr] : '0;
    assign free_pages  = free_q;
    assign drop_cnt    = drop_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_pcie_bf_para_buf.sv
// Scoreboard bench for pcie_bf_para_buf: a default-parameter instance (A) and
// an NPAGE=4 / NUM_CH=4 / REC_BEATS=3 instance (B) share the stimulus bus.
module tb_pcie_bf_para_buf;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic w_clk = 1'b0;
    logic w_rst = 1'b1;
    always #5 w_clk = ~w_clk;

    int dsel = 0;
    int cyc  = 0;
    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] pd = '0;
    logic [KW-1:0] pk = '0;
    logic          pv = 1'b0, pl = 1'b0;
    logic [7:0]    ra = '0;
    logic          re = 1'b0, rrel = 1'b0;

    logic        a_pvld, a_rvld, b_pvld, b_rvld;
    logic [23:0] a_info, b_info;
    logic [31:0] a_rdata, b_rdata;
    logic [1:0]  a_free;
    logic [2:0]  b_free;
    logic [15:0] a_drop, a_err, b_drop, b_err;

    pcie_bf_para_buf dut_a (
        .w_clk(w_clk), .w_rst(w_rst),
        .pcie_data(pd), .pcie_keep(pk),
        .pcie_valid(pv && (dsel == 0)), .pcie_last(pl),
        .rd_page_vld(a_pvld), .rd_info(a_info),
        .rd_en(re && (dsel == 0)), .rd_addr(ra),
        .rd_data(a_rdata), .rd_vld(a_rvld),
        .rd_release(rrel && (dsel == 0)),
        .free_pages(a_free), .drop_cnt(a_drop), .err_cnt(a_err)
    );

    pcie_bf_para_buf #(.NUM_CH(4), .REC_BEATS(3), .NPAGE(4)) dut_b (
        .w_clk(w_clk), .w_rst(w_rst),
        .pcie_data(pd), .pcie_keep(pk),
        .pcie_valid(pv && (dsel == 1)), .pcie_last(pl),
        .rd_page_vld(b_pvld), .rd_info(b_info),
        .rd_en(re && (dsel == 1)), .rd_addr(ra),
        .rd_data(b_rdata), .rd_vld(b_rvld),
        .rd_release(rrel && (dsel == 1)),
        .free_pages(b_free), .drop_cnt(b_drop), .err_cnt(b_err)
    );

    always @(posedge w_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every presented read word is matched against the oldest
    // outstanding expectation, both in value and in arrival cycle.
    exp_t mon_e;
    always @(negedge w_clk) begin
        if (a_rvld || b_rvld) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL rd_spurious: rd_vld with no outstanding read at cycle %0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("rd_data", a_rvld ? a_rdata : b_rdata, mon_e.d);
                chk("rd_latency", cyc, mon_e.due);
            end
        end
    end

    function automatic logic [31:0] wv(input int p, input int k, input int w, input logic [23:0] info);
        if (k == 0 && w == 0) return {8'h5A, info};
        return {8'(p), 8'(k), 8'(w), 8'hC3};
    endfunction

    function automatic logic [DW-1:0] mkbeat(input int p, input int k, input logic [23:0] info);
        logic [DW-1:0] b;
        for (int w = 0; w < DW/32; w++) b[w*32 +: 32] = wv(p, k, w, info);
        return b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        pv = 1'b1; pd = d; pk = k; pl = l;
        @(posedge w_clk); #1;
        pv = 1'b0; pl = 1'b0;
    endtask

    // keep3_half: beat 3 carries only bytes 0..7; gap_at: idle cycle before that beat.
    task automatic send_pkt(input int p, input int n, input logic [23:0] info,
                            input bit keep3_half, input int gap_at);
        logic [KW-1:0] k;
        for (int b = 0; b < n; b++) begin
            if (b == gap_at) tick(1);
            k = '1;
            if (b == 3 && keep3_half) k = KW'(64'h00FF);
            send_beat(mkbeat(p, b, info), k, b == n - 1);
        end
    endtask

    task automatic rd(input int ch, input int word, input logic [31:0] exp);
        exp_t t;
        ra = (dsel != 0) ? {2'(ch), 6'(word)} : {1'(ch), 7'(word)};
        re = 1'b1;
        t.d = exp;
        t.due = cyc + 3;
        sbq.push_back(t);
        @(posedge w_clk); #1;
        re = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (sbq.size() > 0 && i < 20) begin
            @(posedge w_clk);
            i++;
        end
        #1;
        chk("rd_drain_outstanding", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic pulse_rel();
        rrel = 1'b1;
        @(posedge w_clk); #1;
        rrel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        w_rst = 1'b1;
        tick(3);
        w_rst = 1'b0;

        // Reset state
        chk("rst_free", a_free, 2);
        chk("rst_pvld", a_pvld, 0);
        chk("rst_rvld", a_rvld, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_info", a_info, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_err", a_err, 0);
        chk("rst_free_b", b_free, 4);

        // One clean packet: commit timing, info, reads
        send_pkt(1, 10, 24'hABCDEF, 0, -1);
        chk("s1_pvld_1cyc", a_pvld, 0);
        tick(1);
        chk("s1_pvld_2cyc", a_pvld, 1);
        chk("s1_info", a_info, 24'hABCDEF);
        chk("s1_free", a_free, 1);
        rd(1, 0, wv(1, 5, 0, 24'hABCDEF));
        rd(0, 0, {8'h5A, 24'hABCDEF});
        rd(1, 79, wv(1, 9, 15, 24'hABCDEF));
        rd(0, 37, wv(1, 2, 5, 24'hABCDEF));
        drain();

        // Release, ignored release, then three packets with no release
        pulse_rel();
        chk("s2_free_after_rel", a_free, 2);
        chk("s2_pvld_after_rel", a_pvld, 0);
        pulse_rel();
        chk("s2_rel_empty_free", a_free, 2);
        send_pkt(2, 10, 24'h020202, 0, -1);
        send_pkt(3, 10, 24'h030303, 0, -1);
        send_pkt(4, 10, 24'h040404, 0, -1);
        chk("s2_drop", a_drop, 1);
        chk("s2_free_full", a_free, 0);
        chk("s2_head_info", a_info, 24'h020202);
        rd(0, 20, wv(2, 1, 4, 24'h020202));
        drain();
        pulse_rel();
        chk("s2_next_info", a_info, 24'h030303);
        chk("s2_free_one", a_free, 1);
        rd(1, 16, wv(3, 6, 0, 24'h030303));
        drain();
        pulse_rel();
        chk("s2_free_two", a_free, 2);
        chk("s2_pvld_empty", a_pvld, 0);

        // Early last and overlong packets
        send_pkt(5, 7, 24'h050505, 0, -1);
        tick(1);
        chk("s3_err_early", a_err, 1);
        chk("s3_free_early", a_free, 2);
        chk("s3_pvld_early", a_pvld, 0);
        send_pkt(6, 11, 24'h060606, 0, -1);
        tick(1);
        chk("s3_err_long", a_err, 2);
        chk("s3_free_long", a_free, 2);
        chk("s3_pvld_long", a_pvld, 0);
        chk("s3_drop_same", a_drop, 1);
        send_pkt(7, 10, 24'h070707, 0, -1);
        tick(1);
        chk("s3_clean_pvld", a_pvld, 1);
        chk("s3_clean_info", a_info, 24'h070707);
        rd(1, 79, wv(7, 9, 15, 24'h070707));
        drain();

        // Partial keep over the page previously holding packet 3
        send_pkt(8, 10, 24'h080808, 1, -1);
        tick(1);
        pulse_rel();
        chk("s4_head_info", a_info, 24'h080808);
        rd(0, 48, wv(8, 3, 0, 24'h080808));
        rd(0, 49, wv(8, 3, 1, 24'h080808));
        rd(0, 50, wv(3, 3, 2, 24'h030303));
        rd(0, 63, wv(3, 3, 15, 24'h030303));
        rd(0, 64, wv(8, 4, 0, 24'h080808));
        drain();

        // Reset in the middle of a packet
        for (int b = 0; b < 4; b++) send_beat(mkbeat(9, b, 24'h090909), '1, 1'b0);
        w_rst = 1'b1;
        send_beat(mkbeat(9, 4, 24'h090909), '1, 1'b0);
        w_rst = 1'b0;
        chk("s5_rst_free", a_free, 2);
        chk("s5_rst_pvld", a_pvld, 0);
        chk("s5_rst_info", a_info, 0);
        chk("s5_rst_drop", a_drop, 0);
        chk("s5_rst_err", a_err, 0);
        chk("s5_rst_rvld", a_rvld, 0);
        chk("s5_rst_rdata", a_rdata, 0);
        for (int b = 5; b < 10; b++) send_beat(mkbeat(9, b, 24'h090909), '1, b == 9);
        tick(1);
        chk("s5_tail_err", a_err, 1);
        chk("s5_tail_pvld", a_pvld, 0);
        send_pkt(10, 10, 24'h0A0A0A, 0, 4);
        chk("s5_clean_pvld_1cyc", a_pvld, 0);
        tick(1);
        chk("s5_clean_pvld", a_pvld, 1);
        chk("s5_clean_info", a_info, 24'h0A0A0A);
        chk("s5_clean_free", a_free, 1);
        rd(1, 5, wv(10, 5, 5, 24'h0A0A0A));
        drain();

        // Instance B: first scenario, then commit and release together
        dsel = 1;
        send_pkt(11, 12, 24'h0B0B0B, 0, -1);
        chk("b_pvld_1cyc", b_pvld, 0);
        tick(1);
        chk("b_pvld", b_pvld, 1);
        chk("b_info", b_info, 24'h0B0B0B);
        chk("b_free", b_free, 3);
        rd(1, 0, wv(11, 3, 0, 24'h0B0B0B));
        rd(3, 47, wv(11, 11, 15, 24'h0B0B0B));
        rd(2, 17, wv(11, 7, 1, 24'h0B0B0B));
        drain();
        send_pkt(12, 12, 24'h0C0C0C, 0, -1);
        rrel = 1'b1;
        @(posedge w_clk); #1;
        rrel = 1'b0;
        chk("b_same_cycle_free", b_free, 3);
        chk("b_same_cycle_info", b_info, 24'h0C0C0C);
        chk("b_same_cycle_pvld", b_pvld, 1);
        tick(1);
        chk("b_same_cycle_free_hold", b_free, 3);
        rd(0, 0, {8'h5A, 24'h0C0C0C});
        rd(3, 47, wv(12, 11, 15, 24'h0C0C0C));
        drain();
        pulse_rel();
        chk("b_final_free", b_free, 4);
        chk("b_final_pvld", b_pvld, 0);
        chk("b_err", b_err, 0);
        chk("b_drop", b_drop, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
